// File: rtl/fetch_prefetch_unit_if.sv
// rtl/fetch_prefetch_unit_if.sv - bus bundle between the fetch front end and its decode/ICCM/BIST/controller neighbours
//
// Purpose: groups every non-clock, non-reset signal of fetch_prefetch_unit.
// Modports:
//   master - the fetch unit: drives if_*, fifo_level, bist_rd_*, mem_rd*, mem_wr*
//   slave  - the surroundings: drive redirect_*, if_ready, cntlr_*, bist_* requests, mem_rd_data
interface fetch_prefetch_unit_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_addr;

    logic                   if_valid;
    logic                   if_ready;
    logic [DATA_WIDTH-1:0]  if_instr;
    logic [ADDR_WIDTH-1:0]  if_pc;
    logic [LEVEL_WIDTH-1:0] fifo_level;

    logic                   cntlr_wr;
    logic [ADDR_WIDTH-1:0]  cntlr_waddr;
    logic [DATA_WIDTH-1:0]  cntlr_wr_data;

    logic                   bist_en;
    logic                   bist_rd;
    logic [ADDR_WIDTH-1:0]  bist_raddr;
    logic                   bist_wr;
    logic [ADDR_WIDTH-1:0]  bist_waddr;
    logic [DATA_WIDTH-1:0]  bist_wr_data;
    logic [DATA_WIDTH-1:0]  bist_rd_data;
    logic                   bist_rd_valid;

    logic                   mem_rd;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr;
    logic [DATA_WIDTH-1:0]  mem_rd_data;
    logic                   mem_wr;
    logic [ADDR_WIDTH-1:0]  mem_wr_addr;
    logic [DATA_WIDTH-1:0]  mem_wr_data;

    modport master (
        input  redirect_valid, redirect_addr, if_ready,
        input  cntlr_wr, cntlr_waddr, cntlr_wr_data,
        input  bist_en, bist_rd, bist_raddr, bist_wr, bist_waddr, bist_wr_data,
        input  mem_rd_data,
        output if_valid, if_instr, if_pc, fifo_level,
        output bist_rd_data, bist_rd_valid,
        output mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output redirect_valid, redirect_addr, if_ready,
        output cntlr_wr, cntlr_waddr, cntlr_wr_data,
        output bist_en, bist_rd, bist_raddr, bist_wr, bist_waddr, bist_wr_data,
        output mem_rd_data,
        input  if_valid, if_instr, if_pc, fifo_level,
        input  bist_rd_data, bist_rd_valid,
        input  mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch front end with prefetch FIFO, redirect flush and BIST takeover
//
// Purpose: owns the fetch PC, issues sequential ICCM word reads, buffers the
// returned instructions in a FIFO_DEPTH-entry prefetch FIFO and hands them to
// decode with a valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_prefetch_unit_if.master (redirect, decode handshake,
//          controller write, BIST request/response, ICCM read/write port)
module fetch_prefetch_unit #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_prefetch_unit_if.master bus
);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  deliver_pc;
    logic                   inflight;
    logic [ADDR_WIDTH-1:0]  inflight_pc;
    logic                   bist_en_q;
    logic                   bist_rd_valid_q;

    logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc   [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [LEVEL_WIDTH-1:0] count;

    logic                   redirect_pending;
    logic                   bist_flush;
    logic                   flush;
    logic [LEVEL_WIDTH:0]   occupancy;
    logic                   issue;
    logic                   push;
    logic                   pop;

    // The redirect blocks issue in its own cycle rather than the one after,
    // so the first read at the new address goes out at t+1 and nothing that
    // was issued before the flush can land in the cleared FIFO.
    assign redirect_pending = bus.redirect_valid;

    assign bist_flush = bus.bist_en && !bist_en_q;
    assign flush      = redirect_pending || bist_flush;

    // FIFO slots already owned: buffered entries plus the read whose data
    // returns next cycle. Issuing only below FIFO_DEPTH means a push always
    // finds a free slot.
    assign occupancy = {1'b0, count} + {{LEVEL_WIDTH{1'b0}}, inflight};
    assign issue     = !rst && !bus.bist_en && !redirect_pending
                       && (occupancy < (LEVEL_WIDTH+1)'(FIFO_DEPTH));

    assign push = inflight && !flush;
    assign pop  = (count != '0) && bus.if_ready && !redirect_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc        <= RESET_PC;
            deliver_pc      <= RESET_PC;
            inflight        <= 1'b0;
            inflight_pc     <= RESET_PC;
            bist_en_q       <= 1'b0;
            bist_rd_valid_q <= 1'b0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
        end else begin
            bist_en_q       <= bus.bist_en;
            bist_rd_valid_q <= bus.bist_en && bus.bist_rd;
            inflight        <= issue;
            inflight_pc     <= fetch_pc;

            if (redirect_pending) begin
                fetch_pc   <= bus.redirect_addr;
                deliver_pc <= bus.redirect_addr;
            end else begin
                if (pop) begin
                    deliver_pc <= deliver_pc + 1'b1;
                end
                // BIST entry rewinds fetch to the first instruction decode
                // has not yet taken, including one popped this same cycle.
                if (bist_flush) begin
                    fetch_pc <= pop ? deliver_pc + 1'b1 : deliver_pc;
                end else if (issue) begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_rd_data;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end

    assign bus.if_valid   = (count != '0);
    assign bus.if_instr   = fifo_data[rd_ptr];
    assign bus.if_pc      = fifo_pc[rd_ptr];
    assign bus.fifo_level = count;

    assign bus.bist_rd_data  = bus.mem_rd_data;
    assign bus.bist_rd_valid = bist_rd_valid_q;

    always_comb begin
        bus.mem_rd      = issue;
        bus.mem_rd_addr = fetch_pc;
        bus.mem_wr      = !rst && bus.cntlr_wr;
        bus.mem_wr_addr = bus.cntlr_waddr;
        bus.mem_wr_data = bus.cntlr_wr_data;
        if (bus.bist_en) begin
            bus.mem_rd      = !rst && bus.bist_rd;
            bus.mem_rd_addr = bus.bist_raddr;
            bus.mem_wr      = !rst && bus.bist_wr;
            bus.mem_wr_addr = bus.bist_waddr;
            bus.mem_wr_data = bus.bist_wr_data;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   issues;

    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

    fetch_prefetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return {16'hC0DE, 5'b0, a};
    endfunction

    // ICCM model: one-cycle registered read
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rd_data <= word_at(bus.mem_rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.if_ready       = 1'b0;
        bus.cntlr_wr       = 1'b0;
        bus.cntlr_waddr    = '0;
        bus.cntlr_wr_data  = '0;
        bus.bist_en        = 1'b0;
        bus.bist_rd        = 1'b0;
        bus.bist_raddr     = '0;
        bus.bist_wr        = 1'b0;
        bus.bist_waddr     = '0;
        bus.bist_wr_data   = '0;
    endtask

    // Leaves the bench 1 time unit into cycle 0 after reset release
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        #1;
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_bist_rd_valid", bus.bist_rd_valid, 0);
        chk("rst_fifo_level", bus.fifo_level, 0);
        chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);

        // Streaming with decode always ready
        do_reset();
        bus.if_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t1_mem_rd", bus.mem_rd, 1);
            chk("t1_mem_rd_addr", bus.mem_rd_addr, 64'(k));
            if (k >= 2) begin
                chk("t1_if_valid", bus.if_valid, 1);
                chk("t1_if_pc", bus.if_pc, 64'(k - 2));
                chk("t1_if_instr", bus.if_instr, 64'(word_at(AW'(k - 2))));
            end else begin
                chk("t1_if_valid_fill", bus.if_valid, 0);
            end
            tick();
        end

        // Backpressure: four issues fill the FIFO, then release
        do_reset();
        issues = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.mem_rd) issues++;
            if (k == 5 || k == 9) begin
                chk("t2_fifo_level", bus.fifo_level, 4);
                chk("t2_if_valid", bus.if_valid, 1);
                chk("t2_if_pc_hold", bus.if_pc, 0);
            end
            tick();
        end
        chk("t2_issue_count", 64'(issues), 4);
        bus.if_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("t2_resume_valid", bus.if_valid, 1);
            chk("t2_resume_pc", bus.if_pc, 64'(j));
            tick();
        end

        // Redirect with 3 buffered entries and one read in flight, plus a
        // handshake in the same cycle that must not consume the head
        do_reset();
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 11'h100;
        bus.if_ready       = 1'b1;
        #1;
        chk("t3_level_before", bus.fifo_level, 3);
        chk("t3_rd_during_redirect", bus.mem_rd, 0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_rd_t1", bus.mem_rd, 1);
        chk("t3_rd_addr_t1", bus.mem_rd_addr, 11'h100);
        chk("t3_level_flushed", bus.fifo_level, 0);
        chk("t3_valid_t1", bus.if_valid, 0);
        tick();
        #1;
        chk("t3_valid_t2", bus.if_valid, 0);
        tick();
        #1;
        chk("t3_valid_t3", bus.if_valid, 1);
        chk("t3_pc_t3", bus.if_pc, 11'h100);
        tick();
        #1;
        chk("t3_pc_t4", bus.if_pc, 11'h101);
        chk("t3_instr_t4", bus.if_instr, 64'(word_at(11'h101)));

        // Address wrap at the top of the ICCM
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 11'h7FE;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (2) tick();
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("t4_wrap_valid", bus.if_valid, 1);
            chk("t4_wrap_pc", bus.if_pc, 64'(AW'(11'h7FE + j)));
            tick();
        end

        // BIST takeover after decode has consumed PC 5
        do_reset();
        bus.if_ready = 1'b1;
        repeat (8) tick();
        bus.if_ready     = 1'b0;
        bus.bist_en      = 1'b1;
        bus.bist_rd      = 1'b1;
        bus.bist_raddr   = 11'h055;
        bus.bist_wr      = 1'b1;
        bus.bist_waddr   = 11'h066;
        bus.bist_wr_data = 32'hDEADBEEF;
        #1;
        chk("t5_head_pc", bus.if_pc, 6);
        chk("t5_mem_rd", bus.mem_rd, 1);
        chk("t5_mem_rd_addr", bus.mem_rd_addr, 11'h055);
        chk("t5_mem_wr", bus.mem_wr, 1);
        chk("t5_mem_wr_addr", bus.mem_wr_addr, 11'h066);
        chk("t5_mem_wr_data", bus.mem_wr_data, 32'hDEADBEEF);
        chk("t5_bist_rd_valid_0", bus.bist_rd_valid, 0);
        tick();
        bus.bist_rd       = 1'b0;
        bus.bist_wr       = 1'b0;
        bus.cntlr_wr      = 1'b1;
        bus.cntlr_waddr   = 11'h012;
        bus.cntlr_wr_data = 32'h00001234;
        #1;
        chk("t5_bist_rd_valid_1", bus.bist_rd_valid, 1);
        chk("t5_bist_rd_data", bus.bist_rd_data, 64'(word_at(11'h055)));
        chk("t5_mem_rd_idle", bus.mem_rd, 0);
        chk("t5_mem_wr_bist_owned", bus.mem_wr, 0);
        chk("t5_level_flushed", bus.fifo_level, 0);
        tick();
        bus.bist_en  = 1'b0;
        bus.if_ready = 1'b1;
        #1;
        chk("t5_bist_rd_valid_off", bus.bist_rd_valid, 0);
        chk("t5_cntlr_wr", bus.mem_wr, 1);
        chk("t5_cntlr_waddr", bus.mem_wr_addr, 11'h012);
        chk("t5_cntlr_wdata", bus.mem_wr_data, 32'h00001234);
        chk("t5_resume_rd", bus.mem_rd, 1);
        chk("t5_resume_rd_addr", bus.mem_rd_addr, 6);
        tick();
        bus.cntlr_wr = 1'b0;
        tick();
        #1;
        chk("t5_resume_valid", bus.if_valid, 1);
        chk("t5_resume_pc6", bus.if_pc, 6);
        tick();
        #1;
        chk("t5_resume_pc7", bus.if_pc, 7);

        // Asynchronous reset in the middle of streaming
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_if_valid", bus.if_valid, 0);
        chk("t6_rst_level", bus.fifo_level, 0);
        chk("t6_rst_mem_rd", bus.mem_rd, 0);
        chk("t6_rst_mem_rd_addr", bus.mem_rd_addr, 0);
        chk("t6_rst_bist_rd_valid", bus.bist_rd_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t6_restart_rd", bus.mem_rd, 1);
        chk("t6_restart_addr", bus.mem_rd_addr, 0);
        tick();
        tick();
        #1;
        chk("t6_restart_valid", bus.if_valid, 1);
        chk("t6_restart_pc", bus.if_pc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
